// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, builds a
// 16-bit frame per full scan, debounces whole frames and reports single keys.
module keypad_scanner #(
    parameter int SCAN_DIV = 5000,
    parameter int DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_DOWN
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

    logic [3:0]       row_m;
    logic [3:0]       row_s;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [15:0]      frame;
    logic [15:0]      prev_frame;
    logic [15:0]      accepted;
    logic [CNT_W-1:0] stable_cnt;
    logic             released;

    logic             div_term;
    logic             frame_term;
    logic [15:0]      sampled;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             single;
    logic [3:0]       key_pos;
    logic [3:0]       code;

    // Frame bit index is {row, col}; the code table follows that layout.
    function automatic logic [3:0] pos_code(input logic [3:0] pos);
        case (pos)
            4'd0:    pos_code = 4'h1;
            4'd1:    pos_code = 4'h2;
            4'd2:    pos_code = 4'h3;
            4'd3:    pos_code = 4'hA;
            4'd4:    pos_code = 4'h4;
            4'd5:    pos_code = 4'h5;
            4'd6:    pos_code = 4'h6;
            4'd7:    pos_code = 4'hB;
            4'd8:    pos_code = 4'h7;
            4'd9:    pos_code = 4'h8;
            4'd10:   pos_code = 4'h9;
            4'd11:   pos_code = 4'hC;
            4'd12:   pos_code = 4'h0;
            4'd13:   pos_code = 4'hF;
            4'd14:   pos_code = 4'hE;
            default: pos_code = 4'hD;
        endcase
    endfunction

    assign div_term   = (div_cnt == DIV_LAST);
    assign frame_term = div_term && (col_idx == 2'd3);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sampled = frame;
        if (div_term) begin
            for (int r = 0; r < 4; r++) begin
                sampled[{2'(r), col_idx}] = ~row_s[r];
            end
        end
    end

    always_comb begin
        cnt_next = CNT_W'(1);
        if (sampled == prev_frame) begin
            cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
        end
    end

    // Acceptance fires only on the transition into saturation, once per stable period.
    assign accept = frame_term && (cnt_next == CNT_MAX) && (stable_cnt != CNT_MAX);
    assign single = ($countones(sampled) == 1);

    always_comb begin
        key_pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (sampled[i]) begin
                key_pos = 4'(i);
            end
        end
    end

    assign code     = pos_code(key_pos);
    assign KEY_DOWN = |accepted;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_m      <= 4'hF;
            row_s      <= 4'hF;
            div_cnt    <= '0;
            col_idx    <= 2'd0;
            COL        <= 4'b1110;
            frame      <= '0;
            prev_frame <= '0;
            accepted   <= '0;
            stable_cnt <= '0;
            released   <= 1'b1;
            KEY        <= 4'h0;
            KEY_VALID  <= 1'b0;
        end else begin
            row_m     <= ROW;
            row_s     <= row_m;
            KEY_VALID <= 1'b0;

            if (div_term) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                COL     <= {COL[2:0], COL[3]};
                frame   <= sampled;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (frame_term) begin
                prev_frame <= sampled;
                stable_cnt <= cnt_next;
            end

            // A repeat of the same key needs an accepted all-zero frame in between.
            if (accept) begin
                accepted <= sampled;
                if (sampled == 16'h0000) begin
                    released <= 1'b1;
                end else if (single && (released || (code != KEY))) begin
                    KEY       <= code;
                    KEY_VALID <= 1'b1;
                    released  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives ROW from COL, a
// phase-level reference model queues expected key codes, a monitor checks pulses.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;

    localparam logic [3:0] CODE_LUT [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEY;
    logic       KEY_VALID;
    logic       KEY_DOWN;

    logic [15:0] pressed = 16'h0000;

    logic [3:0] exp_q [$];
    logic [3:0] m_key;
    bit         m_released;
    bit         prev_valid = 1'b0;
    int         tests = 0;
    int         fails = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ROW       (ROW),
        .COL       (COL),
        .KEY       (KEY),
        .KEY_VALID (KEY_VALID),
        .KEY_DOWN  (KEY_DOWN)
    );

    always #5 CLK = ~CLK;

    // Physical keypad: a pressed key shorts its row to the driven (low) column.
    function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] col);
        logic [3:0] r;
        r = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int rr = 0; rr < 4; rr++) begin
                    if (p[rr * 4 + c]) r[rr] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign ROW = rows_for(pressed, COL);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_key      = 4'h0;
        m_released = 1'b1;
        exp_q.delete();
    endtask

    // Reference: each held matrix is eventually accepted; apply the key-report rules.
    task automatic model_apply(input logic [15:0] m);
        logic [3:0] c;
        if (m == 16'h0000) begin
            m_released = 1'b1;
        end else if ($countones(m) == 1) begin
            c = 4'h0;
            for (int i = 0; i < 16; i++) if (m[i]) c = CODE_LUT[i];
            if (m_released || (c != m_key)) begin
                exp_q.push_back(c);
                m_key      = c;
                m_released = 1'b0;
            end
        end
    endtask

    task automatic hold(input logic [15:0] m, input int frames);
        pressed = m;
        model_apply(m);
        repeat (frames * FRAME) @(posedge CLK);
        @(negedge CLK);
        check("pulses_drained", 16'(exp_q.size()), 16'd0);
        check("key_down", {15'b0, KEY_DOWN}, {15'b0, m != 16'h0000});
        check("key_held", {12'b0, KEY}, {12'b0, m_key});
    endtask

    task automatic check_reset_values();
        check("rst_col", {12'b0, COL}, 16'h000E);
        check("rst_key", {12'b0, KEY}, 16'h0000);
        check("rst_valid", {15'b0, KEY_VALID}, 16'h0000);
        check("rst_down", {15'b0, KEY_DOWN}, 16'h0000);
    endtask

    always @(negedge CLK) begin
        if (!RESET && KEY_VALID) begin
            check("valid_consecutive", {15'b0, prev_valid}, 16'h0000);
            check("pulse_expected", {15'b0, exp_q.size() != 0}, 16'h0001);
            if (exp_q.size() != 0) check("key_on_valid", {12'b0, KEY}, {12'b0, exp_q.pop_front()});
        end
        prev_valid = KEY_VALID && !RESET;
    end

    initial begin
        logic [15:0] m;
        int a, b;

        model_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_values();
        RESET = 1'b0;

        // Idle: ten frames of no keys, column rotation checked every cycle.
        model_apply(16'h0000);
        for (int i = 0; i < 10 * FRAME; i++) begin
            check("col_rotation", {12'b0, COL}, {12'b0, ~(4'b0001 << ((i / SD) % 4))});
            check("idle_down", {15'b0, KEY_DOWN}, 16'h0000);
            @(negedge CLK);
        end

        // Key '5' held, then released.
        hold(16'h0001 << 5, 6);
        hold(16'h0000, 5);

        // Key 'D' bouncing for two frames, then settled.
        pressed = 16'h0001 << 15;
        repeat (FRAME) @(posedge CLK);
        pressed = 16'h0000;
        repeat (FRAME) @(posedge CLK);
        hold(16'h0001 << 15, 6);
        hold(16'h0000, 5);

        // '1' and '2' together, then '2' released.
        hold(16'h0003, 6);
        hold(16'h0001, 6);
        hold(16'h0000, 5);

        // '7' pressed, released, pressed again.
        hold(16'h0001 << 8, 5);
        hold(16'h0000, 5);
        hold(16'h0001 << 8, 5);
        hold(16'h0000, 5);

        // Reset while '5' is mid-debounce.
        pressed = 16'h0001 << 5;
        repeat (FRAME + FRAME / 2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_values();
        check("rst_queue_empty", 16'(exp_q.size()), 16'd0);
        model_reset();
        RESET = 1'b0;
        hold(16'h0001 << 5, 6);
        hold(16'h0000, 5);

        // Randomised phases: none, single key, or two keys.
        for (int p = 0; p < 24; p++) begin
            case ($urandom_range(0, 2))
                0: m = 16'h0000;
                1: m = 16'h0001 << $urandom_range(0, 15);
                default: begin
                    a = $urandom_range(0, 15);
                    do b = $urandom_range(0, 15); while (b == a);
                    m = (16'h0001 << a) | (16'h0001 << b);
                end
            endcase
            hold(m, $urandom_range(5, 8));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
